// File: rtl/bus_serial_port.sv
// Memory-mapped 8N1 UART responder for the CPU6 bus: STATUS at BASE_ADDR, DATA at BASE_ADDR+1.
// Define BUS_SERIAL_RX_FIFO_EN to replace the RX holding register with a 4-entry FIFO.
module bus_serial_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter logic [15:0] CLKS_PER_BIT = 16'd104
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic        writeEnBus,
  input  logic        readEnBus,
  input  logic [7:0]  dataOutBus,
  output logic [7:0]  dataInBus,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] BAUD_LAST = CLKS_PER_BIT - 16'd1;
  localparam logic [15:0] BAUD_HALF = (CLKS_PER_BIT >> 1) - 16'd1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic sel_status, sel_data, status_rd, data_rd, data_wr;

  assign sel_status = (addressBus == BASE_ADDR);
  assign sel_data   = (addressBus == DATA_ADDR);
  assign status_rd  = readEnBus & sel_status;
  assign data_rd    = readEnBus & sel_data;
  assign data_wr    = writeEnBus & sel_data;

  // ---------------- transmitter ----------------
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_baud;
  logic [3:0]  tx_bit;
  logic [7:0]  tx_shift, tx_hold;
  logic        tx_full, tx_load, tx_bit_end;

  always_comb begin
    tx_bit_end = (tx_baud == BAUD_LAST);
    tx_load    = 1'b0;
    tx_state_n = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_full) begin tx_load = 1'b1; tx_state_n = TX_START; end
      TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_bit == 4'd7) tx_state_n = TX_STOP;
      TX_STOP:
        // Chain straight into the next start bit so back-to-back frames have no idle gap.
        if (tx_bit_end) begin
          if (tx_full) begin tx_load = 1'b1; tx_state_n = TX_START; end
          else tx_state_n = TX_IDLE;
        end
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txd      <= 1'b1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_hold  <= '0;
      tx_full  <= 1'b0;
    end else begin
      if (data_wr && !tx_full) begin
        tx_hold <= dataOutBus;
        tx_full <= 1'b1;
      end else if (tx_load) begin
        tx_full <= 1'b0;
      end
      if (tx_load) begin
        tx_shift <= tx_hold;
        tx_baud  <= '0;
        tx_bit   <= '0;
        txd      <= 1'b0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_bit_end) begin
          tx_baud <= '0;
          case (tx_state)
            TX_START: txd <= tx_shift[0];
            TX_DATA: begin
              txd      <= (tx_bit == 4'd7) ? 1'b1 : tx_shift[1];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 4'd1;
            end
            default:  txd <= 1'b1;
          endcase
        end else begin
          tx_baud <= tx_baud + 16'd1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t   rx_state, rx_state_n;
  logic        rx_sync1, rx_sync2, rx_prev;
  logic [15:0] rx_baud;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_fall, rx_sample, rx_done, rx_push, ferr_evt, ovr_evt;
  logic        frame_err, overrun, rx_ready, rx_full;
  logic [7:0]  rx_head;

  always_comb begin
    rx_fall    = rx_prev & ~rx_sync2;
    rx_sample  = (rx_state == RX_START) ? (rx_baud == BAUD_HALF) : (rx_baud == BAUD_LAST);
    rx_done    = 1'b0;
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
      RX_START: if (rx_sample) rx_state_n = rx_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_sample && rx_bit == 4'd7) rx_state_n = RX_STOP;
      RX_STOP:  if (rx_sample) begin rx_state_n = RX_IDLE; rx_done = 1'b1; end
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  assign rx_push  = rx_done & rx_sync2;
  assign ferr_evt = rx_done & ~rx_sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync1 <= rxd;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      if (rx_state == RX_IDLE) begin
        rx_baud <= '0;
        rx_bit  <= '0;
      end else if (rx_sample) begin
        rx_baud <= '0;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rx_sync2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_baud <= rx_baud + 16'd1;
      end
    end
  end

`ifdef BUS_SERIAL_RX_FIFO_EN
  logic [7:0] rx_fifo [4];
  logic [1:0] rx_wptr, rx_rptr;
  logic [2:0] rx_count;
  logic       rx_pop, rx_wr;

  always_comb begin
    rx_full  = (rx_count == 3'd4);
    rx_ready = (rx_count != 3'd0);
    rx_head  = rx_fifo[rx_rptr];
    rx_pop   = data_rd & rx_ready;
    rx_wr    = rx_push & (~rx_full | rx_pop);
    ovr_evt  = rx_push & rx_full & ~rx_pop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) rx_fifo[i] <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_wr) begin
        rx_fifo[rx_wptr] <= rx_shift;
        rx_wptr          <= rx_wptr + 2'd1;
      end
      if (rx_pop) rx_rptr <= rx_rptr + 2'd1;
      rx_count <= rx_count + {2'b00, rx_wr} - {2'b00, rx_pop};
    end
  end
`else
  logic [7:0] rx_hold;

  assign rx_full = 1'b0;
  assign rx_head = rx_hold;
  // A DATA read coinciding with a good stop bit swaps in the new byte instead of overrunning.
  assign ovr_evt = rx_push & rx_ready & ~data_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_hold  <= '0;
      rx_ready <= 1'b0;
    end else if (rx_push && (!rx_ready || data_rd)) begin
      rx_hold  <= rx_shift;
      rx_ready <= 1'b1;
    end else if (data_rd) begin
      rx_ready <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_evt)       frame_err <= 1'b1;
      else if (status_rd) frame_err <= 1'b0;
      if (ovr_evt)        overrun <= 1'b1;
      else if (status_rd) overrun <= 1'b0;
    end
  end

  assign irq = rx_ready;

  always_comb begin
    dataInBus = '0;
    if (sel_status)
      dataInBus = {rx_full, 3'b000, frame_err, overrun, ~tx_full, rx_ready};
    else if (sel_data && rx_ready)
      dataInBus = rx_head;
  end

endmodule

// File: tb/tb_bus_serial_port.sv
// Directed self-checking bench for bus_serial_port (CLKS_PER_BIT=4, BASE_ADDR=16'hF200).
module tb_bus_serial_port;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addressBus = '0;
  logic        writeEnBus = 1'b0;
  logic        readEnBus = 1'b0;
  logic [7:0]  dataOutBus = '0;
  logic [7:0]  dataInBus;
  logic        txd;
  logic        rxd = 1'b1;
  logic        irq;

  int checks = 0;
  int errors = 0;

  bus_serial_port #(.BASE_ADDR(16'hF200), .CLKS_PER_BIT(16'd4)) dut (
    .clock(clock), .reset(reset), .addressBus(addressBus), .writeEnBus(writeEnBus),
    .readEnBus(readEnBus), .dataOutBus(dataOutBus), .dataInBus(dataInBus),
    .txd(txd), .rxd(rxd), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addressBus = a; dataOutBus = d; writeEnBus = 1'b1;
    @(negedge clock);
    writeEnBus = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    addressBus = a; readEnBus = 1'b1;
    #1 d = dataInBus;
    @(negedge clock);
    readEnBus = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [7:0] d);
    @(negedge clock);
    addressBus = a;
    #1 d = dataInBus;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (4) @(negedge clock);
    end
    rxd = stop;
    repeat (4) @(negedge clock);
    rxd = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Expected txd level i cycles into a frame carrying d.
  function automatic logic tx_level(input logic [7:0] d, input int i);
    int j;
    j = i / 4;
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return d[j-1];
  endfunction

  initial begin
    logic [7:0] v;
    logic       saw_low;

    repeat (3) @(negedge clock);
    check("reset_txd", txd, 8'h01);
    check("reset_irq", irq, 8'h00);
    reset = 1'b0;
    bus_read(16'hF200, v); check("reset_status", v, 8'h02);
    bus_read(16'hF201, v); check("reset_data", v, 8'h00);
    bus_read(16'hF300, v); check("unmapped_read", v, 8'h00);

    bus_write(16'hF200, 8'h55);
    repeat (6) @(negedge clock);
    check("status_write_no_tx", txd, 8'h01);
    peek(16'hF200, v); check("status_write_ignored", v, 8'h02);

    bus_write(16'hF201, 8'hA5);
    addressBus = 16'hF200;
    #1;
    check("tx_busy_after_write", dataInBus, 8'h00);
    check("txd_high_at_write", txd, 8'h01);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check($sformatf("tx_a5_c%0d", i), txd, {7'd0, tx_level(8'hA5, i)});
      if (i == 0) check("tx_ready_after_load", dataInBus, 8'h02);
    end
    repeat (4) @(negedge clock);
    check("tx_idle_after_a5", txd, 8'h01);

    bus_write(16'hF201, 8'h01);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      check($sformatf("tx_b2b_c%0d", i), txd,
            {7'd0, (i < 40) ? tx_level(8'h01, i) : tx_level(8'h80, i - 40)});
      case (i)
        0: begin addressBus = 16'hF201; dataOutBus = 8'h80; writeEnBus = 1'b1; end
        2: begin dataOutBus = 8'hFF; writeEnBus = 1'b1; end
        default: writeEnBus = 1'b0;
      endcase
    end
    saw_low = 1'b0;
    repeat (44) begin
      @(negedge clock);
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    check("tx_dropped_third", saw_low, 8'h00);
    peek(16'hF200, v); check("tx_ready_after_b2b", v, 8'h02);

    rx_frame(8'h3C, 1'b1);
    peek(16'hF200, v); check("rx_status", v, 8'h03);
    check("rx_irq", irq, 8'h01);
    bus_read(16'hF201, v); check("rx_data", v, 8'h3C);
    peek(16'hF200, v); check("rx_status_after_pop", v, 8'h02);
    check("rx_irq_after_pop", irq, 8'h00);

    rxd = 1'b0;
    repeat (2) @(negedge clock);
    rxd = 1'b1;
    repeat (12) @(negedge clock);
    peek(16'hF200, v); check("glitch_status", v, 8'h02);
    check("glitch_irq", irq, 8'h00);

    rx_frame(8'h5A, 1'b0);
    bus_read(16'hF200, v); check("frame_err_status", v, 8'h0A);
    peek(16'hF200, v); check("frame_err_cleared", v, 8'h02);
    check("frame_err_irq", irq, 8'h00);

`ifdef BUS_SERIAL_RX_FIFO_EN
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    rx_frame(8'h33, 1'b1);
    rx_frame(8'h44, 1'b1);
    rx_frame(8'h55, 1'b1);
    peek(16'hF200, v); check("fifo_overrun_status", v, 8'h87);
    bus_read(16'hF201, v); check("fifo_pop0", v, 8'h11);
    bus_read(16'hF201, v); check("fifo_pop1", v, 8'h22);
    bus_read(16'hF201, v); check("fifo_pop2", v, 8'h33);
    bus_read(16'hF201, v); check("fifo_pop3", v, 8'h44);
    bus_read(16'hF200, v); check("fifo_status_drained", v, 8'h06);
`else
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    peek(16'hF200, v); check("overrun_status", v, 8'h07);
    check("overrun_irq", irq, 8'h01);
    bus_read(16'hF201, v); check("overrun_keeps_old", v, 8'h11);
    bus_read(16'hF200, v); check("overrun_status_read", v, 8'h06);
`endif
    peek(16'hF200, v); check("overrun_cleared", v, 8'h02);

    bus_write(16'hF201, 8'hC3);
    repeat (3) @(negedge clock);
    check("midframe_start_bit", txd, 8'h00);
    reset = 1'b1;
    #1;
    check("midframe_reset_txd", txd, 8'h01);
    @(negedge clock);
    reset = 1'b0;
    peek(16'hF200, v); check("midframe_reset_status", v, 8'h02);
    saw_low = 1'b0;
    repeat (44) begin
      @(negedge clock);
      if (txd !== 1'b1) saw_low = 1'b1;
    end
    check("midframe_frame_aborted", saw_low, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
